// File: rtl/alu_exec_stage.sv
// ALU execute stage: computes result and flags at accept time and holds them in a
// 2-entry output buffer with a valid/ready handshake toward memory/writeback.
module alu_exec_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_ctrl,
    input  logic             alu_src,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic [15:0]      imm,
    input  logic [4:0]       dest,
    input  logic             reg_we_in,
    input  logic             mem_we_in,
    input  logic             reg_mux_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             illegal,
    output logic [WIDTH-1:0] store_data,
    output logic [4:0]       dest_out,
    output logic             reg_we_out,
    output logic             mem_we_out,
    output logic             reg_mux_out
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             ovf;
        logic             illegal;
        logic [WIDTH-1:0] store_data;
        logic [4:0]       dest;
        logic             reg_we;
        logic             mem_we;
        logic             reg_mux;
    } entry_t;

    localparam int unsigned Msb = WIDTH - 1;

    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             illegal_op;
    entry_t           new_entry;

    entry_t           slot0_q;
    entry_t           slot1_q;
    logic [1:0]       count_q;
    logic             push;
    logic             pop;

    always_comb begin
        op_b       = alu_src ? rt_data : {{(WIDTH-16){imm[15]}}, imm};
        sum        = rs_data + op_b;
        diff       = rs_data - op_b;
        alu_res    = '0;
        alu_ovf    = 1'b0;
        illegal_op = 1'b0;
        unique case (alu_ctrl)
            3'b001: begin
                alu_res = sum;
                alu_ovf = (rs_data[Msb] == op_b[Msb]) && (sum[Msb] != rs_data[Msb]);
            end
            3'b010: begin
                alu_res = diff;
                alu_ovf = (rs_data[Msb] != op_b[Msb]) && (diff[Msb] != rs_data[Msb]);
            end
            3'b011: alu_res = rs_data & op_b;
            3'b100: alu_res = rs_data | op_b;
            3'b101: alu_res = rs_data ^ op_b;
            3'b110: alu_res = ~(rs_data | op_b);
            3'b111: alu_res = {{(WIDTH-1){1'b0}}, ($signed(rs_data) < $signed(op_b))};
            3'b000: illegal_op = 1'b1;
        endcase
    end

    always_comb begin
        new_entry.result     = alu_res;
        new_entry.zero       = (alu_res == '0);
        new_entry.ovf        = alu_ovf;
        new_entry.illegal    = illegal_op;
        new_entry.store_data = rt_data;
        new_entry.dest       = dest;
        // An undecodable op must never commit architectural state.
        new_entry.reg_we     = reg_we_in & ~illegal_op;
        new_entry.mem_we     = mem_we_in & ~illegal_op;
        new_entry.reg_mux    = reg_mux_in;
    end

    assign in_ready  = (count_q < 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // slot0 is always the head; slot1 only holds the second entry at count 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
            slot0_q <= '0;
            slot1_q <= '0;
        end else if (flush) begin
            count_q <= 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) slot0_q <= new_entry;
                    else                 slot1_q <= new_entry;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    slot0_q <= slot1_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: slot0_q <= new_entry;
                2'b00: ;
            endcase
        end
    end

    assign result      = slot0_q.result;
    assign zero        = slot0_q.zero;
    assign ovf         = slot0_q.ovf;
    assign illegal     = slot0_q.illegal;
    assign store_data  = slot0_q.store_data;
    assign dest_out    = slot0_q.dest;
    assign reg_we_out  = slot0_q.reg_we;
    assign mem_we_out  = slot0_q.mem_we;
    assign reg_mux_out = slot0_q.reg_mux;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: vector table for the ALU plus hand-written
// sequences for backpressure, back-to-back push/pop, flush and reset.
module tb_alu_exec_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, alu_src, out_valid, out_ready;
    logic [2:0]  alu_ctrl;
    logic [31:0] rs_data, rt_data, result, store_data;
    logic [15:0] imm;
    logic [4:0]  dest, dest_out;
    logic        reg_we_in, mem_we_in, reg_mux_in;
    logic        zero, ovf, illegal, reg_we_out, mem_we_out, reg_mux_out;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    alu_exec_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .alu_src(alu_src), .rs_data(rs_data), .rt_data(rt_data),
        .imm(imm), .dest(dest), .reg_we_in(reg_we_in), .mem_we_in(mem_we_in),
        .reg_mux_in(reg_mux_in), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .ovf(ovf), .illegal(illegal),
        .store_data(store_data), .dest_out(dest_out), .reg_we_out(reg_we_out),
        .mem_we_out(mem_we_out), .reg_mux_out(reg_mux_out)
    );

    typedef struct {
        logic [2:0]  ctrl;
        logic        src;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [15:0] imm;
        logic        rwe;
        logic [31:0] exp_res;
        logic        exp_zero;
        logic        exp_ovf;
        logic        exp_ill;
        logic        exp_rwe;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic [2:0] c, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [15:0] i, input logic [4:0] d);
        alu_ctrl = c; alu_src = s; rs_data = a; rt_data = b; imm = i; dest = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] got[4];
    int          n;
    logic        acc;

    initial begin
        vecs[0]  = '{3'b001, 1'b1, 32'd5,        32'd7,        16'h0000, 1'b1, 32'd12,       1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{3'b010, 1'b0, 32'd3,        32'h0000AAAA, 16'h0003, 1'b1, 32'd0,        1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{3'b001, 1'b0, 32'h10,       32'd0,        16'hFFFF, 1'b1, 32'h0000000F, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{3'b001, 1'b1, 32'h7FFFFFFF, 32'd1,        16'h0000, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{3'b111, 1'b1, 32'hFFFFFFFF, 32'd1,        16'h0000, 1'b1, 32'd1,        1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{3'b010, 1'b1, 32'h80000000, 32'd1,        16'h0000, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{3'b110, 1'b1, 32'd0,        32'd0,        16'h0000, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{3'b011, 1'b0, 32'hFFFF1234, 32'd0,        16'h8000, 1'b1, 32'hFFFF0000, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{3'b111, 1'b1, 32'd1,        32'hFFFFFFFF, 16'h0000, 1'b1, 32'd0,        1'b1, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{3'b000, 1'b1, 32'd5,        32'd7,        16'h0000, 1'b1, 32'd0,        1'b1, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{3'b101, 1'b1, 32'hFFFF00FF, 32'h0F0F0F0F, 16'h0000, 1'b1, 32'hF0F00FF0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{3'b010, 1'b1, 32'd5,        32'd7,        16'h0000, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{3'b001, 1'b1, 32'h80000000, 32'h80000000, 16'h0000, 1'b1, 32'd0,        1'b1, 1'b1, 1'b0, 1'b1};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        reg_we_in = 1'b0; mem_we_in = 1'b0; reg_mux_in = 1'b0;
        drive(3'b000, 1'b0, 32'd0, 32'd0, 16'd0, 5'd0);

        // Reset: outputs all zero while rst held
        step();
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_flags", {zero, ovf, illegal}, 0);
        check("rst_store_dest", {store_data, dest_out}, 0);
        check("rst_sideband", {reg_we_out, mem_we_out, reg_mux_out}, 0);
        rst = 1'b0;
        step();
        check("rst_in_ready", in_ready, 1);

        // Vector table, one op at a time with downstream always ready
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].ctrl, vecs[i].src, vecs[i].rs, vecs[i].rt, vecs[i].imm, 5'(i + 1));
            reg_we_in = vecs[i].rwe; reg_mux_in = 1'b1;
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            check($sformatf("v%0d_valid", i), out_valid, 1);
            check($sformatf("v%0d_result", i), result, vecs[i].exp_res);
            check($sformatf("v%0d_flags", i), {zero, ovf, illegal},
                  {vecs[i].exp_zero, vecs[i].exp_ovf, vecs[i].exp_ill});
            check($sformatf("v%0d_reg_we", i), reg_we_out, vecs[i].exp_rwe);
            check($sformatf("v%0d_store", i), store_data, vecs[i].rt);
            check($sformatf("v%0d_dest", i), dest_out, 5'(i + 1));
            step();
            check($sformatf("v%0d_popped", i), out_valid, 0);
        end
        reg_we_in = 1'b0; reg_mux_in = 1'b0;

        // Backpressure: two accepted, third held until downstream drains
        out_ready = 1'b0;
        drive(3'b011, 1'b1, 32'hF0F0, 32'h0FF0, 16'd0, 5'd1);
        in_valid = 1'b1;
        check("bp_ready0", in_ready, 1);
        step();
        drive(3'b100, 1'b1, 32'hF0F0, 32'h0FF0, 16'd0, 5'd2);
        check("bp_ready1", in_ready, 1);
        step();
        drive(3'b101, 1'b1, 32'hF0F0, 32'h0FF0, 16'd0, 5'd3);
        check("bp_full", in_ready, 0);
        step();
        check("bp_still_full", in_ready, 0);
        check("bp_head_stable", result, 32'h00F0);
        check("bp_head_dest", dest_out, 5'd1);
        out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            acc = in_valid && in_ready;
            if (out_valid && n < 4) begin
                got[n] = result;
                n++;
            end
            step();
            if (acc) in_valid = 1'b0;
        end
        check("bp_count", n, 3);
        check("bp_out0", got[0], 32'h00F0);
        check("bp_out1", got[1], 32'hFFF0);
        check("bp_out2", got[2], 32'hFF00);
        check("bp_input_released", in_valid, 0);

        // Back-to-back ops with downstream always ready: count stays at 1
        drive(3'b001, 1'b1, 32'd0, 32'd1, 16'd0, 5'd0);
        in_valid = 1'b1;
        step();
        for (int i = 1; i < 5; i++) begin
            drive(3'b001, 1'b1, 32'(3 * i), 32'(i + 1), 16'd0, 5'(i));
            check($sformatf("pp%0d_ready", i), in_ready, 1);
            check($sformatf("pp%0d_valid", i), out_valid, 1);
            check($sformatf("pp%0d_result", i), result, 32'(4 * (i - 1) + 1));
            step();
        end
        in_valid = 1'b0;
        check("pp_last", result, 32'd17);
        step();
        check("pp_drained", out_valid, 0);

        // Flush with two entries buffered and a same-cycle input
        out_ready = 1'b0;
        drive(3'b001, 1'b1, 32'd1, 32'd1, 16'd0, 5'd1);
        in_valid = 1'b1;
        step();
        drive(3'b001, 1'b1, 32'd2, 32'd2, 16'd0, 5'd2);
        step();
        check("fl_full", in_ready, 0);
        drive(3'b001, 1'b1, 32'd100, 32'd1, 16'd0, 5'd9);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_valid", out_valid, 0);
        check("fl_ready", in_ready, 1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        check("fl_no_ghost", out_valid, 0);

        // Illegal op with write enables requested
        drive(3'b000, 1'b1, 32'h1234, 32'h5678, 16'd0, 5'd7);
        reg_we_in = 1'b1; mem_we_in = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0; reg_we_in = 1'b0; mem_we_in = 1'b0;
        check("ill_valid", out_valid, 1);
        check("ill_flag", illegal, 1);
        check("ill_result", result, 0);
        check("ill_we", {reg_we_out, mem_we_out}, 2'b00);
        step();

        // Reset mid-stall discards both entries and clears outputs
        out_ready = 1'b0;
        drive(3'b100, 1'b1, 32'h55, 32'hAA, 16'd0, 5'd3);
        in_valid = 1'b1;
        step();
        step();
        check("rs_full", in_ready, 0);
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rs_valid", out_valid, 0);
        check("rs_ready", in_ready, 1);
        check("rs_result", result, 0);
        out_ready = 1'b1;
        step();
        check("rs_stays_empty", out_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
